// File: rtl/spike_dec_pkg.sv
// Shared types and helpers for the spike rate decoder.
// Holds default widths, the accumulate FSM state type and the saturating increment.
package spike_dec_pkg;

    localparam int DEF_N_LANES = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_WIN_W   = 8;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

    // count + spike, pinned at all-ones instead of wrapping
    function automatic logic [DEF_CNT_W-1:0] sat_inc(
        input logic [DEF_CNT_W-1:0] count,
        input logic                 spike
    );
        if (spike && (count != '1)) begin
            return count + 1'b1;
        end
        return count;
    endfunction

endpackage

// File: rtl/spike_lane_counter.sv
// One saturating per-lane spike counter with synchronous clear.
// Ports: clk, rst (async high), clear, en, spike; sat_count = count incl. this cycle's spike.
module spike_lane_counter
    import spike_dec_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] sat_count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // sat_count is what the counter would hold after this cycle, so the
    // window-end cycle's own spike can be captured in the snapshot.
    if (CNT_W == DEF_CNT_W) begin : g_pkg_inc
        assign sat_count = sat_inc(count_q, spike);
    end else begin : g_gen_inc
        assign sat_count = (spike && (count_q != '1)) ? count_q + 1'b1 : count_q;
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = sat_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per lane over a programmable window, streams a snapshot lane by lane
// over valid/ready and reports the argmax lane. Ports: clk, rst, enable, window_len,
// spike_in, out_valid/out_ready/out_lane/out_count/out_last, win_valid/win_lane/win_count, overrun.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter  int N_LANES = DEF_N_LANES,
    parameter  int CNT_W   = DEF_CNT_W,
    parameter  int WIN_W   = DEF_WIN_W,
    localparam int LANE_W  = $clog2(N_LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WIN_W-1:0]  window_len,
    input  logic [N_LANES-1:0] spike_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_lane,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic              win_valid,
    output logic [LANE_W-1:0] win_lane,
    output logic [CNT_W-1:0]  win_count,
    output logic              overrun
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

    state_e            state_q, state_d;
    logic [WIN_W-1:0]  len_q, len_d;
    logic [WIN_W-1:0]  cyc_q, cyc_d;
    logic              cnt_clr, cnt_en, win_end;

    logic [N_LANES-1:0][CNT_W-1:0] sat_all;
    logic [N_LANES-1:0][CNT_W-1:0] snap_q, snap_d;

    logic              busy_q, busy_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [LANE_W-1:0] best_lane_q, best_lane_d;
    logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
    logic [LANE_W-1:0] win_lane_q, win_lane_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic              win_valid_q, win_valid_d;
    logic              overrun_q, overrun_d;

    logic              xfer, last_xfer, capture, take;
    logic [CNT_W-1:0]  cur_cnt;
    logic [LANE_W-1:0] fb_lane;
    logic [CNT_W-1:0]  fb_cnt;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        spike_lane_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clear    (cnt_clr),
            .en       (cnt_en),
            .spike    (spike_in[i]),
            .sat_count(sat_all[i])
        );
    end

    assign win_end = (state_q == ACCUM) && enable && (cyc_q == len_q - 1'b1);

    // Accumulate FSM: window end restarts counters in the same edge (no gap).
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cyc_d   = cyc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (enable && (window_len != '0)) begin
                    state_d = ACCUM;
                    len_d   = window_len;
                    cyc_d   = '0;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                    cyc_d   = '0;
                end else if (win_end) begin
                    cnt_clr = 1'b1;
                    cyc_d   = '0;
                    if (window_len == '0) begin
                        state_d = IDLE;
                    end else begin
                        len_d = window_len;
                    end
                end else begin
                    cnt_en = 1'b1;
                    cyc_d  = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain: busy_q is still set on the out_last transfer edge, so a window
    // ending on that edge is dropped.
    assign xfer      = busy_q && out_ready;
    assign last_xfer = xfer && (lane_q == LAST_LANE);
    assign capture   = win_end && !busy_q;
    assign cur_cnt   = snap_q[lane_q];

    // Lane 0 seeds the running best; strict > keeps ties on the lower lane.
    assign take    = (lane_q == '0) || (cur_cnt > best_cnt_q);
    assign fb_lane = take ? lane_q : best_lane_q;
    assign fb_cnt  = take ? cur_cnt : best_cnt_q;

    always_comb begin
        busy_d      = busy_q;
        lane_d      = lane_q;
        snap_d      = snap_q;
        best_lane_d = best_lane_q;
        best_cnt_d  = best_cnt_q;
        win_lane_d  = win_lane_q;
        win_cnt_d   = win_cnt_q;
        win_valid_d = 1'b0;
        overrun_d   = overrun_q;
        if (capture) begin
            busy_d = 1'b1;
            lane_d = '0;
            snap_d = sat_all;
        end else if (xfer) begin
            best_lane_d = fb_lane;
            best_cnt_d  = fb_cnt;
            if (last_xfer) begin
                busy_d      = 1'b0;
                lane_d      = '0;
                win_lane_d  = fb_lane;
                win_cnt_d   = fb_cnt;
                win_valid_d = 1'b1;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
        if (!enable) begin
            overrun_d = 1'b0;
        end else if (win_end && busy_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cyc_q       <= '0;
            snap_q      <= '0;
            busy_q      <= 1'b0;
            lane_q      <= '0;
            best_lane_q <= '0;
            best_cnt_q  <= '0;
            win_lane_q  <= '0;
            win_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cyc_q       <= cyc_d;
            snap_q      <= snap_d;
            busy_q      <= busy_d;
            lane_q      <= lane_d;
            best_lane_q <= best_lane_d;
            best_cnt_q  <= best_cnt_d;
            win_lane_q  <= win_lane_d;
            win_cnt_q   <= win_cnt_d;
            win_valid_q <= win_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = busy_q;
    assign out_lane  = lane_q;
    assign out_count = cur_cnt;
    assign out_last  = busy_q && (lane_q == LAST_LANE);
    assign win_valid = win_valid_q;
    assign win_lane  = win_lane_q;
    assign win_count = win_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with hand-computed expected counts.
// Checks reset, streaming, backpressure, wide windows, overrun, ties and async reset.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] window_len;
    logic [7:0] spike_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_lane;
    logic [7:0] out_count;
    logic       out_last;
    logic       win_valid;
    logic [2:0] win_lane;
    logic [7:0] win_count;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int exp_c [8];
    int k;

    spike_rate_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .window_len(window_len),
        .spike_in  (spike_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_count (out_count),
        .out_last  (out_last),
        .win_valid (win_valid),
        .win_lane  (win_lane),
        .win_count (win_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input int a0, input int a1, input int a2, input int a3,
                           input int a4, input int a5, input int a6, input int a7);
        exp_c[0] = a0; exp_c[1] = a1; exp_c[2] = a2; exp_c[3] = a3;
        exp_c[4] = a4; exp_c[5] = a5; exp_c[6] = a6; exp_c[7] = a7;
    endtask

    // Called on the first out_valid cycle with out_ready=1.
    task automatic drain(input string tag, input int wl, input int wc);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 1);
            chk($sformatf("%s_lane%0d", tag, i), 32'(out_lane), 32'(i));
            chk($sformatf("%s_count%0d", tag, i), 32'(out_count), 32'(exp_c[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(out_last), 32'(i == 7));
            chk($sformatf("%s_winv_low%0d", tag, i), 32'(win_valid), 0);
            tick();
        end
        chk({tag, "_valid_end"}, 32'(out_valid), 0);
        chk({tag, "_last_end"}, 32'(out_last), 0);
        chk({tag, "_winv"}, 32'(win_valid), 1);
        chk({tag, "_win_lane"}, 32'(win_lane), 32'(wl));
        chk({tag, "_win_count"}, 32'(win_count), 32'(wc));
        tick();
        chk({tag, "_winv_pulse"}, 32'(win_valid), 0);
        chk({tag, "_win_lane_hold"}, 32'(win_lane), 32'(wl));
    endtask

    // Scenario-1 window: len 4, lane0 always, lane3 on cycles 1 and 3.
    task automatic start_s1(input string tag);
        window_len = 8'd4;
        enable     = 1'b1;
        out_ready  = 1'b0;
        spike_in   = 8'h00;
        tick();
        spike_in = 8'h01; tick();
        spike_in = 8'h09; tick();
        spike_in = 8'h01; tick();
        spike_in = 8'h09;
        chk({tag, "_valid_before_end"}, 32'(out_valid), 0);
        tick();
        spike_in = 8'h00;
        chk({tag, "_valid_after_end"}, 32'(out_valid), 1);
        enable = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        window_len = 8'd0;
        spike_in   = 8'h00;
        out_ready  = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_lane", 32'(out_lane), 0);
        chk("rst_count", 32'(out_count), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_winv", 32'(win_valid), 0);
        chk("rst_win_lane", 32'(win_lane), 0);
        chk("rst_win_count", 32'(win_count), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        tick();

        // 1: basic window
        start_s1("s1");
        out_ready = 1'b1;
        set_exp(4, 0, 0, 2, 0, 0, 0, 0);
        drain("s1", 0, 4);

        // 2: backpressure 1,0,0 repeating
        window_len = 8'd3;
        enable     = 1'b1;
        out_ready  = 1'b0;
        tick();
        spike_in = 8'hFF; tick();
        spike_in = 8'hAA; tick();
        spike_in = 8'h0F; tick();
        spike_in = 8'h00;
        enable   = 1'b0;
        set_exp(2, 3, 2, 3, 1, 2, 1, 2);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            chk("s2_valid", 32'(out_valid), 1);
            chk("s2_lane", 32'(out_lane), 32'(k));
            chk("s2_count", 32'(out_count), 32'(exp_c[k]));
            chk("s2_last", 32'(out_last), 32'(k == 7));
            out_ready = ((c % 3) == 0);
            tick();
            if (out_ready) k++;
        end
        chk("s2_delivered", 32'(k), 8);
        chk("s2_valid_end", 32'(out_valid), 0);
        chk("s2_winv", 32'(win_valid), 1);
        chk("s2_win_lane", 32'(win_lane), 1);
        chk("s2_win_count", 32'(win_count), 3);
        out_ready = 1'b1;
        tick();

        // 3: max window, then 200
        window_len = 8'd255;
        enable     = 1'b1;
        spike_in   = 8'h04;
        tick();
        window_len = 8'd200;
        repeat (254) tick();
        chk("s3_valid_before_end", 32'(out_valid), 0);
        tick();
        window_len = 8'd0;
        set_exp(0, 0, 255, 0, 0, 0, 0, 0);
        drain("s3a", 2, 255);
        repeat (190) tick();
        chk("s3_valid_before_end2", 32'(out_valid), 0);
        tick();
        spike_in = 8'h00;
        set_exp(0, 0, 200, 0, 0, 0, 0, 0);
        drain("s3b", 2, 200);
        enable = 1'b0;
        tick();

        // 4: overrun with stalled drain
        window_len = 8'd2;
        enable     = 1'b1;
        out_ready  = 1'b0;
        tick();
        spike_in = 8'h81; tick();
        spike_in = 8'h01; tick();
        chk("s4_valid", 32'(out_valid), 1);
        chk("s4_overrun_pre", 32'(overrun), 0);
        spike_in = 8'hFF; tick();
        chk("s4_overrun_mid", 32'(overrun), 0);
        window_len = 8'd0;
        tick();
        spike_in = 8'h00;
        chk("s4_overrun_set", 32'(overrun), 1);
        chk("s4_hold_lane", 32'(out_lane), 0);
        chk("s4_hold_count", 32'(out_count), 2);
        tick();
        chk("s4_overrun_sticky", 32'(overrun), 1);
        chk("s4_hold_count2", 32'(out_count), 2);
        out_ready = 1'b1;
        set_exp(2, 0, 0, 0, 0, 0, 0, 1);
        drain("s4", 0, 2);
        chk("s4_overrun_after", 32'(overrun), 1);
        enable = 1'b0;
        tick();
        chk("s4_overrun_clr", 32'(overrun), 0);

        // 5: tie, then aborted window
        window_len = 8'd3;
        enable     = 1'b1;
        tick();
        spike_in = 8'h23; tick();
        spike_in = 8'h22; tick();
        tick();
        spike_in = 8'h00;
        enable   = 1'b0;
        set_exp(1, 3, 0, 0, 0, 3, 0, 0);
        drain("s5", 1, 3);
        window_len = 8'd5;
        enable     = 1'b1;
        tick();
        spike_in = 8'hFF; tick();
        tick();
        enable = 1'b0;
        tick();
        spike_in = 8'h00;
        for (int c = 0; c < 8; c++) begin
            chk("s5_abort_valid", 32'(out_valid), 0);
            tick();
        end

        // 6: async reset mid-drain
        start_s1("s6");
        out_ready = 1'b1;
        repeat (3) tick();
        chk("s6_pre_lane", 32'(out_lane), 3);
        #3;
        rst = 1'b1;
        #1;
        chk("s6_rst_valid", 32'(out_valid), 0);
        chk("s6_rst_lane", 32'(out_lane), 0);
        chk("s6_rst_count", 32'(out_count), 0);
        chk("s6_rst_last", 32'(out_last), 0);
        chk("s6_rst_winv", 32'(win_valid), 0);
        chk("s6_rst_win_lane", 32'(win_lane), 0);
        chk("s6_rst_win_count", 32'(win_count), 0);
        chk("s6_rst_overrun", 32'(overrun), 0);
        tick();
        rst = 1'b0;
        tick();
        start_s1("s6b");
        out_ready = 1'b1;
        set_exp(4, 0, 0, 2, 0, 0, 0, 0);
        drain("s6b", 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
